// File: rtl/regfile_pkg.sv
// Shared register-file types and constants, reused by the ID and WB stages.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 32;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_wb_reg_read_port.sv
// One combinational read port: NUM_REGS:1 mux, register-0 force and, when
// REGFILE_BYPASS_EN is defined, the same-cycle write-through bypass.
module reg_read_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic [ADDR_W-1:0] readreg_i,
`ifdef REGFILE_BYPASS_EN
  input  logic              regwrite_i,
  input  logic [ADDR_W-1:0] writereg_i,
  input  logic [DATA_W-1:0] writedata_i,
`endif
  output logic [DATA_W-1:0] readdata_o
);
  import regfile_pkg::*;

  logic              is_zero_s;
  logic              bypass_hit_s;
  logic [DATA_W-1:0] stored_s;

  // Select the stored word and qualify the index against register 0.
  always_comb begin
    stored_s  = regs_i[readreg_i];
    is_zero_s = (readreg_i == ADDR_W'(ZERO_REG));
  end

  // Same-cycle write target match; never hits for register 0.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    bypass_hit_s = regwrite_i && (writereg_i != ADDR_W'(ZERO_REG)) && (writereg_i == readreg_i);
`else
    bypass_hit_s = 1'b0;
`endif
  end

  // Final operand: zero force wins over bypass, bypass wins over storage.
  always_comb begin
    readdata_o = stored_s;
    if (is_zero_s) begin
      readdata_o = {DATA_W{1'b0}};
    end else if (bypass_hit_s) begin
`ifdef REGFILE_BYPASS_EN
      readdata_o = writedata_i;
`else
      readdata_o = stored_s;
`endif
    end else begin
      readdata_o = stored_s;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS integer register file fed by write-back, with two ID read ports and a
// commit counter. Define REGFILE_BYPASS_EN for the write-through bypass.
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic [CNT_W-1:0]  commit_cnt
);
  import regfile_pkg::*;

  // Register 0 has no storage; entries 1..NUM_REGS-1 only.
  logic [DATA_W-1:0] regs_q    [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d    [1:NUM_REGS-1];
  logic [DATA_W-1:0] rd_view_s [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              we_s;

  // A write is architecturally visible only when it targets a real register.
  always_comb begin
    we_s = regwrite && (writereg != ADDR_W'(ZERO_REG));
  end

  // Write decode into next-state storage.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (we_s && (writereg == ADDR_W'(i))) begin
        regs_d[i] = writedata;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Commit counter advances once per visible write and wraps naturally.
  always_comb begin
    if (we_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Storage and counter; reset takes priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Full-width view for the read muxes, with a constant zero at index 0.
  always_comb begin
    rd_view_s[0] = {DATA_W{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_view_s[i] = regs_q[i];
    end
  end

  reg_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_port1 (
    .regs_i     (rd_view_s),
    .readreg_i  (readreg1),
`ifdef REGFILE_BYPASS_EN
    .regwrite_i (regwrite),
    .writereg_i (writereg),
    .writedata_i(writedata),
`endif
    .readdata_o (readdata1)
  );

  reg_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_port2 (
    .regs_i     (rd_view_s),
    .readreg_i  (readreg2),
`ifdef REGFILE_BYPASS_EN
    .regwrite_i (regwrite),
    .writereg_i (writereg),
    .writedata_i(writedata),
`endif
    .readdata_o (readdata2)
  );

  assign commit_cnt = cnt_q;

endmodule
